// File: rtl/rat_pkg.sv
// Shared definitions for the RAT control unit: FSM states, opcode encodings,
// datapath select encodings and the bundled control-strobe struct.
package rat_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_INTR  = 2'd3
  } state_t;

  // Register/branch forms: {ir[17:13], ir[1:0]}
  localparam logic [6:0] OP_AND   = 7'b0000000;
  localparam logic [6:0] OP_OR    = 7'b0000001;
  localparam logic [6:0] OP_EXOR  = 7'b0000010;
  localparam logic [6:0] OP_TEST  = 7'b0000011;
  localparam logic [6:0] OP_ADD   = 7'b0000100;
  localparam logic [6:0] OP_ADDC  = 7'b0000101;
  localparam logic [6:0] OP_SUB   = 7'b0000110;
  localparam logic [6:0] OP_SUBC  = 7'b0000111;
  localparam logic [6:0] OP_CMP   = 7'b0001000;
  localparam logic [6:0] OP_MOV   = 7'b0001001;
  localparam logic [6:0] OP_LD    = 7'b0001010;
  localparam logic [6:0] OP_ST    = 7'b0001011;
  localparam logic [6:0] OP_BRN   = 7'b0010000;
  localparam logic [6:0] OP_CALL  = 7'b0010001;
  localparam logic [6:0] OP_BREQ  = 7'b0010010;
  localparam logic [6:0] OP_BRNE  = 7'b0010011;
  localparam logic [6:0] OP_BRCS  = 7'b0010100;
  localparam logic [6:0] OP_BRCC  = 7'b0010101;
  localparam logic [6:0] OP_LSL   = 7'b0100000;
  localparam logic [6:0] OP_LSR   = 7'b0100001;
  localparam logic [6:0] OP_ROL   = 7'b0100010;
  localparam logic [6:0] OP_ROR   = 7'b0100011;
  localparam logic [6:0] OP_ASR   = 7'b0100100;
  localparam logic [6:0] OP_PUSH  = 7'b0100101;
  localparam logic [6:0] OP_POP   = 7'b0100110;
  localparam logic [6:0] OP_WSP   = 7'b0101000;
  localparam logic [6:0] OP_CLC   = 7'b0110000;
  localparam logic [6:0] OP_SEC   = 7'b0110001;
  localparam logic [6:0] OP_RET   = 7'b0110010;
  localparam logic [6:0] OP_RETIE = 7'b0110011;
  localparam logic [6:0] OP_SEI   = 7'b0110100;
  localparam logic [6:0] OP_CLI   = 7'b0110101;
  localparam logic [6:0] OP_RETID = 7'b0110110;

  // Immediate forms: ir[17:13] only
  localparam logic [4:0] OP_ANDI  = 5'b10000;
  localparam logic [4:0] OP_ORI   = 5'b10001;
  localparam logic [4:0] OP_EXORI = 5'b10010;
  localparam logic [4:0] OP_TESTI = 5'b10011;
  localparam logic [4:0] OP_ADDI  = 5'b10100;
  localparam logic [4:0] OP_ADDCI = 5'b10101;
  localparam logic [4:0] OP_SUBI  = 5'b10110;
  localparam logic [4:0] OP_SUBCI = 5'b10111;
  localparam logic [4:0] OP_CMPI  = 5'b11000;
  localparam logic [4:0] OP_IN    = 5'b11001;
  localparam logic [4:0] OP_OUT   = 5'b11010;
  localparam logic [4:0] OP_MOVI  = 5'b11011;
  localparam logic [4:0] OP_LDI   = 5'b11100;
  localparam logic [4:0] OP_STI   = 5'b11101;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADDC = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SUBC = 4'd3;
  localparam logic [3:0] ALU_CMP  = 4'd4;
  localparam logic [3:0] ALU_AND  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_EXOR = 4'd7;
  localparam logic [3:0] ALU_TEST = 4'd8;
  localparam logic [3:0] ALU_LSL  = 4'd9;
  localparam logic [3:0] ALU_LSR  = 4'd10;
  localparam logic [3:0] ALU_ROL  = 4'd11;
  localparam logic [3:0] ALU_ROR  = 4'd12;
  localparam logic [3:0] ALU_ASR  = 4'd13;
  localparam logic [3:0] ALU_MOV  = 4'd14;

  localparam logic [1:0] PC_SEL_IMM = 2'd0;
  localparam logic [1:0] PC_SEL_SCR = 2'd1;
  localparam logic [1:0] PC_SEL_VEC = 2'd2;

  localparam logic [1:0] SCR_ADR_REG  = 2'd0;
  localparam logic [1:0] SCR_ADR_IMM  = 2'd1;
  localparam logic [1:0] SCR_ADR_SP   = 2'd2;
  localparam logic [1:0] SCR_ADR_SPM1 = 2'd3;

  localparam logic [1:0] RF_SEL_ALU = 2'd0;
  localparam logic [1:0] RF_SEL_SCR = 2'd1;
  localparam logic [1:0] RF_SEL_SP  = 2'd2;
  localparam logic [1:0] RF_SEL_IN  = 2'd3;

  typedef struct packed {
    logic       pc_ld;
    logic       pc_inc;
    logic [1:0] pc_mux_sel;
    logic       rf_wr;
    logic [1:0] rf_wr_sel;
    logic [3:0] alu_sel;
    logic       alu_opy_sel;
    logic       sp_ld;
    logic       sp_incr;
    logic       sp_decr;
    logic       scr_we;
    logic [1:0] scr_adr_sel;
    logic       scr_data_sel;
    logic       flg_c_ld;
    logic       flg_c_set;
    logic       flg_c_clr;
    logic       flg_z_ld;
    logic       flg_z_clr;
    logic       flg_ld_sel;
    logic       flg_shad_ld;
    logic       i_set;
    logic       i_clr;
    logic       io_strb;
    logic       rst_out;
  } ctrl_t;

endpackage

// File: rtl/rat_control_unit_decode.sv
// Purely combinational opcode-to-strobe table for the EXEC state.
module rat_decode
  import rat_pkg::*;
(
  input  logic [4:0] opcode_hi,
  input  logic [1:0] opcode_lo,
  input  logic       c_flag,
  input  logic       z_flag,
  output ctrl_t      ctrl
);

  logic       is_alu;
  logic       flags_only;
  logic [3:0] alu_op;

  always_comb begin
    ctrl       = '0;
    is_alu     = 1'b0;
    flags_only = 1'b0;
    alu_op     = ALU_ADD;
    if (opcode_hi[4]) begin
      // Immediate forms: opcode_lo carries immediate bits and is ignored
      case (opcode_hi)
        OP_ANDI:  begin is_alu = 1'b1; alu_op = ALU_AND;  end
        OP_ORI:   begin is_alu = 1'b1; alu_op = ALU_OR;   end
        OP_EXORI: begin is_alu = 1'b1; alu_op = ALU_EXOR; end
        OP_TESTI: begin is_alu = 1'b1; alu_op = ALU_TEST; flags_only = 1'b1; end
        OP_ADDI:  begin is_alu = 1'b1; alu_op = ALU_ADD;  end
        OP_ADDCI: begin is_alu = 1'b1; alu_op = ALU_ADDC; end
        OP_SUBI:  begin is_alu = 1'b1; alu_op = ALU_SUB;  end
        OP_SUBCI: begin is_alu = 1'b1; alu_op = ALU_SUBC; end
        OP_CMPI:  begin is_alu = 1'b1; alu_op = ALU_CMP;  flags_only = 1'b1; end
        OP_IN:    begin ctrl.rf_wr = 1'b1; ctrl.rf_wr_sel = RF_SEL_IN; end
        OP_OUT:   ctrl.io_strb = 1'b1;
        OP_MOVI:  begin ctrl.rf_wr = 1'b1; ctrl.alu_sel = ALU_MOV; ctrl.alu_opy_sel = 1'b1; end
        OP_LDI:   begin ctrl.rf_wr = 1'b1; ctrl.rf_wr_sel = RF_SEL_SCR; ctrl.scr_adr_sel = SCR_ADR_IMM; end
        OP_STI:   begin ctrl.scr_we = 1'b1; ctrl.scr_adr_sel = SCR_ADR_IMM; end
        default:  ;
      endcase
    end else begin
      case ({opcode_hi, opcode_lo})
        OP_AND:  begin is_alu = 1'b1; alu_op = ALU_AND;  end
        OP_OR:   begin is_alu = 1'b1; alu_op = ALU_OR;   end
        OP_EXOR: begin is_alu = 1'b1; alu_op = ALU_EXOR; end
        OP_TEST: begin is_alu = 1'b1; alu_op = ALU_TEST; flags_only = 1'b1; end
        OP_ADD:  begin is_alu = 1'b1; alu_op = ALU_ADD;  end
        OP_ADDC: begin is_alu = 1'b1; alu_op = ALU_ADDC; end
        OP_SUB:  begin is_alu = 1'b1; alu_op = ALU_SUB;  end
        OP_SUBC: begin is_alu = 1'b1; alu_op = ALU_SUBC; end
        OP_CMP:  begin is_alu = 1'b1; alu_op = ALU_CMP;  flags_only = 1'b1; end
        OP_LSL:  begin is_alu = 1'b1; alu_op = ALU_LSL;  end
        OP_LSR:  begin is_alu = 1'b1; alu_op = ALU_LSR;  end
        OP_ROL:  begin is_alu = 1'b1; alu_op = ALU_ROL;  end
        OP_ROR:  begin is_alu = 1'b1; alu_op = ALU_ROR;  end
        OP_ASR:  begin is_alu = 1'b1; alu_op = ALU_ASR;  end
        OP_MOV:  begin ctrl.rf_wr = 1'b1; ctrl.alu_sel = ALU_MOV; end
        OP_LD:   begin ctrl.rf_wr = 1'b1; ctrl.rf_wr_sel = RF_SEL_SCR; ctrl.scr_adr_sel = SCR_ADR_REG; end
        OP_ST:   begin ctrl.scr_we = 1'b1; ctrl.scr_adr_sel = SCR_ADR_REG; end
        OP_BRN:  ctrl.pc_ld = 1'b1;
        OP_BREQ: ctrl.pc_ld = z_flag;
        OP_BRNE: ctrl.pc_ld = ~z_flag;
        OP_BRCS: ctrl.pc_ld = c_flag;
        OP_BRCC: ctrl.pc_ld = ~c_flag;
        OP_CALL: begin
          ctrl.pc_ld        = 1'b1;
          ctrl.scr_we       = 1'b1;
          ctrl.scr_adr_sel  = SCR_ADR_SPM1;
          ctrl.scr_data_sel = 1'b1;
          ctrl.sp_decr      = 1'b1;
        end
        OP_RET, OP_RETID, OP_RETIE: begin
          ctrl.pc_ld       = 1'b1;
          ctrl.pc_mux_sel  = PC_SEL_SCR;
          ctrl.scr_adr_sel = SCR_ADR_SP;
          ctrl.sp_incr     = 1'b1;
          if ({opcode_hi, opcode_lo} != OP_RET) begin
            ctrl.flg_ld_sel = 1'b1;
            ctrl.flg_c_ld   = 1'b1;
            ctrl.flg_z_ld   = 1'b1;
            ctrl.i_clr      = ({opcode_hi, opcode_lo} == OP_RETID);
            ctrl.i_set      = ({opcode_hi, opcode_lo} == OP_RETIE);
          end
        end
        OP_PUSH: begin ctrl.scr_we = 1'b1; ctrl.scr_adr_sel = SCR_ADR_SPM1; ctrl.sp_decr = 1'b1; end
        OP_POP:  begin
          ctrl.rf_wr       = 1'b1;
          ctrl.rf_wr_sel   = RF_SEL_SCR;
          ctrl.scr_adr_sel = SCR_ADR_SP;
          ctrl.sp_incr     = 1'b1;
        end
        OP_WSP:  ctrl.sp_ld     = 1'b1;
        OP_CLC:  ctrl.flg_c_clr = 1'b1;
        OP_SEC:  ctrl.flg_c_set = 1'b1;
        OP_SEI:  ctrl.i_set     = 1'b1;
        OP_CLI:  ctrl.i_clr     = 1'b1;
        default: ;
      endcase
    end

    // Logical ops force C low; the flag register ranks clr above ld
    if (is_alu) begin
      ctrl.alu_sel     = alu_op;
      ctrl.alu_opy_sel = opcode_hi[4];
      ctrl.rf_wr       = ~flags_only;
      ctrl.flg_c_ld    = 1'b1;
      ctrl.flg_z_ld    = 1'b1;
      ctrl.flg_c_clr   = (alu_op == ALU_AND) || (alu_op == ALU_OR) || (alu_op == ALU_EXOR);
    end
  end

endmodule

// File: rtl/rat_control_unit.sv
// RAT CPU control FSM: sequences reset, fetch/execute and interrupt entry,
// driving every datapath strobe as a combinational decode of state.
module rat_control_unit
  import rat_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode_hi,
  input  logic [1:0] opcode_lo,
  input  logic       c_flag,
  input  logic       z_flag,
  input  logic       int_req,
  input  logic       i_flag,
  output logic       pc_ld,
  output logic       pc_inc,
  output logic [1:0] pc_mux_sel,
  output logic       rf_wr,
  output logic [1:0] rf_wr_sel,
  output logic [3:0] alu_sel,
  output logic       alu_opy_sel,
  output logic       sp_ld,
  output logic       sp_incr,
  output logic       sp_decr,
  output logic       scr_we,
  output logic [1:0] scr_adr_sel,
  output logic       scr_data_sel,
  output logic       flg_c_ld,
  output logic       flg_c_set,
  output logic       flg_c_clr,
  output logic       flg_z_ld,
  output logic       flg_z_clr,
  output logic       flg_ld_sel,
  output logic       flg_shad_ld,
  output logic       i_set,
  output logic       i_clr,
  output logic       io_strb,
  output logic       rst_out
);

  state_t state_q, state_d;
  ctrl_t  exec_ctrl, ctrl;

  rat_decode u_decode (
    .opcode_hi (opcode_hi),
    .opcode_lo (opcode_lo),
    .c_flag    (c_flag),
    .z_flag    (z_flag),
    .ctrl      (exec_ctrl)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  state_d = ST_FETCH;
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC:  state_d = (int_req && i_flag) ? ST_INTR : ST_FETCH;
      ST_INTR:  state_d = ST_FETCH;
      default:  state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      ST_INIT: begin
        ctrl.rst_out   = 1'b1;
        ctrl.flg_c_clr = 1'b1;
        ctrl.flg_z_clr = 1'b1;
        ctrl.i_clr     = 1'b1;
      end
      ST_FETCH: ctrl.pc_inc = 1'b1;
      ST_EXEC:  ctrl = exec_ctrl;
      ST_INTR: begin
        ctrl.pc_ld        = 1'b1;
        ctrl.pc_mux_sel   = PC_SEL_VEC;
        ctrl.scr_we       = 1'b1;
        ctrl.scr_adr_sel  = SCR_ADR_SPM1;
        ctrl.scr_data_sel = 1'b1;
        ctrl.sp_decr      = 1'b1;
        ctrl.flg_shad_ld  = 1'b1;
        ctrl.flg_c_clr    = 1'b1;
        ctrl.flg_z_clr    = 1'b1;
        ctrl.i_clr        = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_ld        = ctrl.pc_ld;
  assign pc_inc       = ctrl.pc_inc;
  assign pc_mux_sel   = ctrl.pc_mux_sel;
  assign rf_wr        = ctrl.rf_wr;
  assign rf_wr_sel    = ctrl.rf_wr_sel;
  assign alu_sel      = ctrl.alu_sel;
  assign alu_opy_sel  = ctrl.alu_opy_sel;
  assign sp_ld        = ctrl.sp_ld;
  assign sp_incr      = ctrl.sp_incr;
  assign sp_decr      = ctrl.sp_decr;
  assign scr_we       = ctrl.scr_we;
  assign scr_adr_sel  = ctrl.scr_adr_sel;
  assign scr_data_sel = ctrl.scr_data_sel;
  assign flg_c_ld     = ctrl.flg_c_ld;
  assign flg_c_set    = ctrl.flg_c_set;
  assign flg_c_clr    = ctrl.flg_c_clr;
  assign flg_z_ld     = ctrl.flg_z_ld;
  assign flg_z_clr    = ctrl.flg_z_clr;
  assign flg_ld_sel   = ctrl.flg_ld_sel;
  assign flg_shad_ld  = ctrl.flg_shad_ld;
  assign i_set        = ctrl.i_set;
  assign i_clr        = ctrl.i_clr;
  assign io_strb      = ctrl.io_strb;
  assign rst_out      = ctrl.rst_out;

endmodule

// File: tb/tb_rat_control_unit.sv
// Bench for rat_control_unit: directed test-plan steps followed by random
// opcode/flag/interrupt traffic checked against a mnemonic-level model.
module tb_rat_control_unit;
  import rat_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] opcode_hi = '0;
  logic [1:0] opcode_lo = '0;
  logic       c_flag = 1'b0, z_flag = 1'b0, int_req = 1'b0, i_flag = 1'b0;

  logic       pc_ld, pc_inc, rf_wr, alu_opy_sel, sp_ld, sp_incr, sp_decr, scr_we;
  logic       scr_data_sel, flg_c_ld, flg_c_set, flg_c_clr, flg_z_ld, flg_z_clr;
  logic       flg_ld_sel, flg_shad_ld, i_set, i_clr, io_strb, rst_out;
  logic [1:0] pc_mux_sel, rf_wr_sel, scr_adr_sel;
  logic [3:0] alu_sel;

  ctrl_t obs;
  int    tests = 0, fails = 0;
  int    phase = 0;  // 0 reset, 1 fetch, 2 execute, 3 interrupt entry
  string reg_ops[int];
  string imm_ops[int];
  int    alu_map[string];

  rat_control_unit dut (
    .clk(clk), .rst(rst), .opcode_hi(opcode_hi), .opcode_lo(opcode_lo),
    .c_flag(c_flag), .z_flag(z_flag), .int_req(int_req), .i_flag(i_flag),
    .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_mux_sel(pc_mux_sel), .rf_wr(rf_wr),
    .rf_wr_sel(rf_wr_sel), .alu_sel(alu_sel), .alu_opy_sel(alu_opy_sel),
    .sp_ld(sp_ld), .sp_incr(sp_incr), .sp_decr(sp_decr), .scr_we(scr_we),
    .scr_adr_sel(scr_adr_sel), .scr_data_sel(scr_data_sel), .flg_c_ld(flg_c_ld),
    .flg_c_set(flg_c_set), .flg_c_clr(flg_c_clr), .flg_z_ld(flg_z_ld),
    .flg_z_clr(flg_z_clr), .flg_ld_sel(flg_ld_sel), .flg_shad_ld(flg_shad_ld),
    .i_set(i_set), .i_clr(i_clr), .io_strb(io_strb), .rst_out(rst_out)
  );

  assign obs = {pc_ld, pc_inc, pc_mux_sel, rf_wr, rf_wr_sel, alu_sel, alu_opy_sel,
                sp_ld, sp_incr, sp_decr, scr_we, scr_adr_sel, scr_data_sel,
                flg_c_ld, flg_c_set, flg_c_clr, flg_z_ld, flg_z_clr, flg_ld_sel,
                flg_shad_ld, i_set, i_clr, io_strb, rst_out};

  always #5 clk = ~clk;

  function automatic ctrl_t exec_model(logic [4:0] hi, logic [1:0] lo, logic c, logic z);
    ctrl_t e = '0;
    bit    imm = hi[4];
    string m = "UNDEF";
    if (imm) begin
      if (imm_ops.exists(int'(hi))) m = imm_ops[int'(hi)];
    end else if (reg_ops.exists(int'({hi, lo}))) begin
      m = reg_ops[int'({hi, lo})];
    end
    // Immediate mnemonics behave as their register twin with operand Y = immediate
    if (imm && m != "IN" && m != "OUT" && m != "UNDEF") m = m.substr(0, m.len() - 2);

    if (alu_map.exists(m)) begin
      e.alu_sel     = 4'(alu_map[m]);
      e.alu_opy_sel = imm;
      e.flg_c_ld    = 1'b1;
      e.flg_z_ld    = 1'b1;
      e.rf_wr       = (m != "TEST" && m != "CMP");
      e.flg_c_clr   = (m == "AND" || m == "OR" || m == "EXOR");
    end
    if ((m == "BRN") || (m == "BREQ" && z) || (m == "BRNE" && !z) ||
        (m == "BRCS" && c) || (m == "BRCC" && !c)) e.pc_ld = 1'b1;
    if (m == "CALL" || m == "PUSH") begin
      e.scr_we = 1'b1; e.scr_adr_sel = SCR_ADR_SPM1; e.sp_decr = 1'b1;
      e.scr_data_sel = (m == "CALL");
      e.pc_ld = (m == "CALL");
    end
    if (m == "RET" || m == "RETID" || m == "RETIE") begin
      e.pc_ld = 1'b1; e.pc_mux_sel = PC_SEL_SCR; e.scr_adr_sel = SCR_ADR_SP; e.sp_incr = 1'b1;
      if (m != "RET") begin
        e.flg_ld_sel = 1'b1; e.flg_c_ld = 1'b1; e.flg_z_ld = 1'b1;
        e.i_clr = (m == "RETID");
        e.i_set = (m == "RETIE");
      end
    end
    if (m == "POP") begin
      e.rf_wr = 1'b1; e.rf_wr_sel = RF_SEL_SCR; e.scr_adr_sel = SCR_ADR_SP; e.sp_incr = 1'b1;
    end
    if (m == "LD") begin
      e.rf_wr = 1'b1; e.rf_wr_sel = RF_SEL_SCR; e.scr_adr_sel = imm ? SCR_ADR_IMM : SCR_ADR_REG;
    end
    if (m == "ST") begin
      e.scr_we = 1'b1; e.scr_adr_sel = imm ? SCR_ADR_IMM : SCR_ADR_REG;
    end
    if (m == "IN")  begin e.rf_wr = 1'b1; e.rf_wr_sel = RF_SEL_IN; end
    if (m == "OUT") e.io_strb = 1'b1;
    if (m == "MOV") begin e.rf_wr = 1'b1; e.alu_sel = ALU_MOV; e.alu_opy_sel = imm; end
    if (m == "WSP") e.sp_ld = 1'b1;
    if (m == "CLC") e.flg_c_clr = 1'b1;
    if (m == "SEC") e.flg_c_set = 1'b1;
    if (m == "SEI") e.i_set = 1'b1;
    if (m == "CLI") e.i_clr = 1'b1;
    return e;
  endfunction

  function automatic ctrl_t model(int ph);
    ctrl_t e = '0;
    case (ph)
      0: begin e.rst_out = 1'b1; e.flg_c_clr = 1'b1; e.flg_z_clr = 1'b1; e.i_clr = 1'b1; end
      1: e.pc_inc = 1'b1;
      2: e = exec_model(opcode_hi, opcode_lo, c_flag, z_flag);
      default: begin
        e.pc_ld = 1'b1; e.pc_mux_sel = PC_SEL_VEC; e.scr_we = 1'b1;
        e.scr_adr_sel = SCR_ADR_SPM1; e.scr_data_sel = 1'b1; e.sp_decr = 1'b1;
        e.flg_shad_ld = 1'b1; e.flg_c_clr = 1'b1; e.flg_z_clr = 1'b1; e.i_clr = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic sample(input string tag);
    ctrl_t exp_c;
    @(negedge clk);
    exp_c = model(phase);
    tests++;
    assert (obs === exp_c) else begin
      fails++;
      $error("FAIL %s phase=%0d op=%b_%b obs=%h exp=%h", tag, phase, opcode_hi, opcode_lo, obs, exp_c);
    end
  endtask

  task automatic check_val(input string tag, input logic [3:0] o, input logic [3:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst)                                  phase = 0;
    else if (phase == 2 && int_req && i_flag) phase = 3;
    else if (phase == 1)                      phase = 2;
    else                                      phase = 1;
    #1;
  endtask

  task automatic set_op(input logic [6:0] op);
    opcode_hi = op[6:2];
    opcode_lo = op[1:0];
  endtask

  initial begin
    reg_ops[int'(OP_AND)]  = "AND";  reg_ops[int'(OP_OR)]    = "OR";
    reg_ops[int'(OP_EXOR)] = "EXOR"; reg_ops[int'(OP_TEST)]  = "TEST";
    reg_ops[int'(OP_ADD)]  = "ADD";  reg_ops[int'(OP_ADDC)]  = "ADDC";
    reg_ops[int'(OP_SUB)]  = "SUB";  reg_ops[int'(OP_SUBC)]  = "SUBC";
    reg_ops[int'(OP_CMP)]  = "CMP";  reg_ops[int'(OP_MOV)]   = "MOV";
    reg_ops[int'(OP_LD)]   = "LD";   reg_ops[int'(OP_ST)]    = "ST";
    reg_ops[int'(OP_BRN)]  = "BRN";  reg_ops[int'(OP_CALL)]  = "CALL";
    reg_ops[int'(OP_BREQ)] = "BREQ"; reg_ops[int'(OP_BRNE)]  = "BRNE";
    reg_ops[int'(OP_BRCS)] = "BRCS"; reg_ops[int'(OP_BRCC)]  = "BRCC";
    reg_ops[int'(OP_LSL)]  = "LSL";  reg_ops[int'(OP_LSR)]   = "LSR";
    reg_ops[int'(OP_ROL)]  = "ROL";  reg_ops[int'(OP_ROR)]   = "ROR";
    reg_ops[int'(OP_ASR)]  = "ASR";  reg_ops[int'(OP_PUSH)]  = "PUSH";
    reg_ops[int'(OP_POP)]  = "POP";  reg_ops[int'(OP_WSP)]   = "WSP";
    reg_ops[int'(OP_CLC)]  = "CLC";  reg_ops[int'(OP_SEC)]   = "SEC";
    reg_ops[int'(OP_RET)]  = "RET";  reg_ops[int'(OP_RETIE)] = "RETIE";
    reg_ops[int'(OP_SEI)]  = "SEI";  reg_ops[int'(OP_CLI)]   = "CLI";
    reg_ops[int'(OP_RETID)] = "RETID";
    imm_ops[int'(OP_ANDI)]  = "ANDI";  imm_ops[int'(OP_ORI)]   = "ORI";
    imm_ops[int'(OP_EXORI)] = "EXORI"; imm_ops[int'(OP_TESTI)] = "TESTI";
    imm_ops[int'(OP_ADDI)]  = "ADDI";  imm_ops[int'(OP_ADDCI)] = "ADDCI";
    imm_ops[int'(OP_SUBI)]  = "SUBI";  imm_ops[int'(OP_SUBCI)] = "SUBCI";
    imm_ops[int'(OP_CMPI)]  = "CMPI";  imm_ops[int'(OP_IN)]    = "IN";
    imm_ops[int'(OP_OUT)]   = "OUT";   imm_ops[int'(OP_MOVI)]  = "MOVI";
    imm_ops[int'(OP_LDI)]   = "LDI";   imm_ops[int'(OP_STI)]   = "STI";
    alu_map["ADD"] = 0;  alu_map["ADDC"] = 1;  alu_map["SUB"] = 2;  alu_map["SUBC"] = 3;
    alu_map["CMP"] = 4;  alu_map["AND"]  = 5;  alu_map["OR"]  = 6;  alu_map["EXOR"] = 7;
    alu_map["TEST"] = 8; alu_map["LSL"]  = 9;  alu_map["LSR"] = 10; alu_map["ROL"]  = 11;
    alu_map["ROR"] = 12; alu_map["ASR"]  = 13;

    // Reset for one cycle, then INIT -> FETCH -> EXEC(ADD)
    rst = 1'b1;
    @(posedge clk); #1;
    phase = 0;
    rst = 1'b0;
    set_op(OP_ADD);
    sample("init");
    check_val("init_rst_out", {3'b0, rst_out}, 4'd1);
    check_val("init_c_clr", {3'b0, flg_c_clr}, 4'd1);
    tick();
    sample("fetch");
    check_val("fetch_pc_inc", {3'b0, pc_inc}, 4'd1);
    tick();
    sample("exec_add");
    check_val("add_rf_wr", {3'b0, rf_wr}, 4'd1);
    check_val("add_flags", {2'b0, flg_c_ld, flg_z_ld}, 4'd3);
    check_val("add_opy", {3'b0, alu_opy_sel}, 4'd0);
    tick();
    sample("after_add");
    check_val("after_add_fetch", {3'b0, pc_inc}, 4'd1);

    // BREQ not taken, then taken
    set_op(OP_BREQ); z_flag = 1'b0;
    tick(); sample("breq_nt");
    check_val("breq_nt_pc_ld", {3'b0, pc_ld}, 4'd0);
    tick(); sample("fetch2");
    z_flag = 1'b1;
    tick(); sample("breq_t");
    check_val("breq_t_pc_ld", {3'b0, pc_ld}, 4'd1);
    check_val("breq_t_sel", {2'b0, pc_mux_sel}, 4'd0);

    // CALL
    tick(); set_op(OP_CALL); sample("fetch3");
    tick(); sample("call");
    check_val("call_strobes", {scr_we, sp_decr, pc_ld, scr_data_sel}, 4'hF);
    check_val("call_adr", {2'b0, scr_adr_sel}, 4'd3);

    // Immediate ignores opcode_lo; undefined opcode is a NOP
    tick(); opcode_hi = OP_ADDI; opcode_lo = 2'b11; sample("fetch4");
    tick(); sample("addi_lo11");
    check_val("addi_opy", {3'b0, alu_opy_sel}, 4'd1);
    tick(); set_op(7'b1111111); sample("fetch5");
    tick(); sample("undef_nop");

    // Interrupt during SEC: strobes kept, then INTR, then FETCH
    tick(); set_op(OP_SEC); int_req = 1'b1; i_flag = 1'b1; sample("fetch6");
    tick(); sample("sec_irq");
    check_val("sec_c_set", {3'b0, flg_c_set}, 4'd1);
    tick(); int_req = 1'b0; sample("intr");
    check_val("intr_sel", {2'b0, pc_mux_sel}, 4'd2);
    check_val("intr_shad_iclr", {2'b0, flg_shad_ld, i_clr}, 4'd3);
    tick(); sample("post_intr");
    check_val("post_intr_fetch", {3'b0, pc_inc}, 4'd1);

    // Request only in FETCH is missed
    int_req = 1'b1;
    tick(); int_req = 1'b0; sample("exec_noirq");
    tick(); sample("missed_irq");
    check_val("missed_irq_fetch", {3'b0, pc_inc}, 4'd1);

    // Reset during INTR
    int_req = 1'b1;
    tick(); sample("exec_irq2");
    tick(); int_req = 1'b0; rst = 1'b1; sample("intr2");
    tick(); rst = 1'b0; sample("rst_in_intr");
    check_val("rst_in_intr_state", {pc_ld, scr_we, sp_decr, rst_out}, 4'd1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      tick();
      opcode_hi = 5'($urandom_range(0, 31));
      opcode_lo = 2'($urandom_range(0, 3));
      c_flag    = 1'($urandom_range(0, 1));
      z_flag    = 1'($urandom_range(0, 1));
      int_req   = 1'($urandom_range(0, 1));
      i_flag    = 1'($urandom_range(0, 1));
      rst       = ($urandom_range(0, 39) == 0);
      sample("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
